csr_unit: RTL

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_counters.sv | 55 +++++
 rtl/csr_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
//   - CSR addresses (mstatus, mtvec, mscratch, mepc, mcause, counters)
//   - SYSTEM funct3 operation codes and privileged-instruction immediates
//   - trap cause codes
//   - FSM state enum for the trap sequencer
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Privileged instructions (funct3 = 000), selected by instr[31:20]
    localparam logic [11:0] PRIV_ECALL = 12'h000;
    localparam logic [11:0] PRIV_MRET  = 12'h302;

    // funct3 codes; bit 2 selects the immediate form, bits [1:0] the operation
    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_RW    = 3'b001;
    localparam logic [2:0] F3_RS    = 3'b010;
    localparam logic [2:0] F3_RC    = 3'b011;
    localparam logic [2:0] F3_RWI   = 3'b101;
    localparam logic [2:0] F3_RSI   = 3'b110;
    localparam logic [2:0] F3_RCI   = 3'b111;
    localparam logic [1:0] OP_RW    = 2'b01;
    localparam logic [1:0] OP_RS    = 2'b10;
    localparam logic [1:0] OP_RC    = 2'b11;

    // Trap cause codes
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    // Trap sequencer state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/csr_counters.sv
// csr_counters: 64-bit mcycle and minstret counters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   retire       : one instruction retired this cycle
//   wr_en        : CSR write strobe from the CSR unit
//   wr_addr      : CSR address of the write
//   wr_data      : 32-bit value for the addressed half
//   mcycle       : cycle counter
//   minstret     : retired-instruction counter
// A write to either half replaces that half and suppresses the increment of
// that counter for the cycle; the other half holds. The 64-bit add carries
// from the low to the high half and wraps from all-ones to zero.
module csr_counters
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [63:0] mcycle,
    output logic [63:0] minstret
);

    logic [63:0] mcycle_reg, mcycle_next;
    logic [63:0] minstret_reg, minstret_next;

    always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + {63'd0, retire};
        if (wr_en) begin
            case (wr_addr)
                CSR_MCYCLE:    mcycle_next   = {mcycle_reg[63:32], wr_data};
                CSR_MCYCLEH:   mcycle_next   = {wr_data, mcycle_reg[31:0]};
                CSR_MINSTRET:  minstret_next = {minstret_reg[63:32], wr_data};
                CSR_MINSTRETH: minstret_next = {wr_data, minstret_reg[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    assign mcycle   = mcycle_reg;
    assign minstret = minstret_reg;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with ecall/mret trap sequencing.
//   clk, rst_n  : clock, asynchronous active-low reset
//   csr_valid   : SYSTEM instruction in execute
//   funct3      : CSR operation / privileged (000)
//   csr_addr    : CSR address, or ecall/mret selector for funct3=000
//   rs1_data    : register source operand
//   zimm        : rs1 index / 5-bit immediate
//   pc          : PC of the execute-stage instruction
//   retire      : one instruction retired this cycle
//   csr_rdata   : old value of the addressed CSR (0 if unimplemented)
//   redirect    : pipeline redirect request
//   redirect_pc : redirect target
//   stall       : hold the front end
//   illegal     : unimplemented CSR accessed
// Optional feature macro CSR_COUNTERS_EN adds mcycle/minstret (B00/B80,
// B02/B82); without it those addresses are illegal.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 'h100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_valid,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic [XLEN-1:0] pc,
    input  logic            retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall,
    output logic            illegal
);

    csr_state_e      state_reg, state_next;
    logic            mie_reg, mpie_reg;
    logic [XLEN-1:0] mtvec_reg, mepc_reg, mcause_reg, mscratch_reg;

    logic            active, is_priv, do_ecall, do_mret, is_csr_op;
    logic            addr_hit, csr_we;
    logic [XLEN-1:0] old_val, src_val, wr_val;

    // pc[0] is never stored (mepc is halfword aligned); retire only feeds counters.
    logic unused_bits;
    assign unused_bits = ^{pc[0], retire};

    // Instructions are ignored while the trap cycle is in flight; gating with
    // rst_n keeps illegal/stall/redirect low for the whole reset window.
    assign active    = rst_n && csr_valid && (state_reg == ST_RUN);
    assign is_priv   = (funct3 == F3_PRIV);
    assign do_ecall  = active && is_priv && (csr_addr == PRIV_ECALL);
    assign do_mret   = active && is_priv && (csr_addr == PRIV_MRET);
    assign is_csr_op = active && (funct3[1:0] != 2'b00);

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    csr_counters u_counters (
        .clk      (clk),
        .rst_n    (rst_n),
        .retire   (retire),
        .wr_en    (csr_we),
        .wr_addr  (csr_addr),
        .wr_data  (wr_val[31:0]),
        .mcycle   (mcycle),
        .minstret (minstret)
    );
`endif

    // Read mux: unimplemented addresses read as zero.
    always_comb begin
        addr_hit = 1'b1;
        old_val  = '0;
        case (csr_addr)
            CSR_MSTATUS:   old_val = XLEN'({mpie_reg, 3'b000, mie_reg, 3'b000});
            CSR_MTVEC:     old_val = mtvec_reg;
            CSR_MSCRATCH:  old_val = mscratch_reg;
            CSR_MEPC:      old_val = mepc_reg;
            CSR_MCAUSE:    old_val = mcause_reg;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    old_val = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH:   old_val = XLEN'(mcycle[63:32]);
            CSR_MINSTRET:  old_val = XLEN'(minstret[31:0]);
            CSR_MINSTRETH: old_val = XLEN'(minstret[63:32]);
`endif
            default:       addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata = old_val;
    assign illegal   = is_csr_op && !addr_hit;
    assign src_val   = funct3[2] ? XLEN'(zimm) : rs1_data;

    always_comb begin
        case (funct3[1:0])
            OP_RW:   wr_val = src_val;
            OP_RS:   wr_val = old_val | src_val;
            default: wr_val = old_val & ~src_val;
        endcase
    end

    // Set/clear forms with zimm==0 (x0 or immediate 0) never write.
    assign csr_we = is_csr_op && addr_hit && ((funct3[1:0] == OP_RW) || (zimm != 5'd0));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_RUN;
        else        state_reg <= state_next;
    end

    // FSM: next state; TRAP always lasts a single cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:  if (do_ecall) state_next = ST_TRAP;
            ST_TRAP: state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // FSM: outputs. Redirect targets come from the current register values,
    // so a same-cycle write to mepc/mtvec cannot affect them.
    always_comb begin
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = mepc_reg;
        if (state_reg == ST_TRAP) begin
            stall       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = mtvec_reg;
        end else if (do_ecall) begin
            stall = 1'b1;
        end else if (do_mret) begin
            redirect = 1'b1;
        end
    end

    // CSR state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mscratch_reg <= '0;
        end else if (do_ecall) begin
            mepc_reg   <= {pc[XLEN-1:1], 1'b0};
            mcause_reg <= XLEN'(CAUSE_ECALL_M);
            mpie_reg   <= mie_reg;
            mie_reg    <= 1'b0;
        end else if (do_mret) begin
            mie_reg  <= mpie_reg;
            mpie_reg <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_reg  <= wr_val[3];
                    mpie_reg <= wr_val[7];
                end
                CSR_MTVEC:    mtvec_reg    <= {wr_val[XLEN-1:2], 2'b00};
                CSR_MSCRATCH: mscratch_reg <= wr_val;
                CSR_MEPC:     mepc_reg     <= {wr_val[XLEN-1:1], 1'b0};
                CSR_MCAUSE:   mcause_reg   <= wr_val;
                default: ;
            endcase
        end
    end

endmodule
